// File: rtl/alu_muldiv_unit.sv
// EX-stage ALU with RV32M multiply/divide on a radix-2 iterative engine.
// Results are registered and handed off through a valid/ready pair.
module alu_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       ALUCode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             busy
);
    localparam logic [1:0] S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3;
    localparam int CW = $clog2(WIDTH) + 1;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [4:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d, lo_q, lo_d, opnd_q, opnd_d, res_q, res_d;
    logic             negq_q, negq_d, negr_q, negr_d, bz_q, bz_d;

    logic             accept, is_mul, is_div, a_sgn, b_sgn;
    logic [WIDTH-1:0] a_mag, b_mag, alu_res;

    assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
    assign accept    = in_valid & in_ready & ~flush;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_MUL) | (state_q == S_DIV);
    assign ALUResult = res_q;

    always_comb begin
        alu_res = '0;
        case (ALUCode)
            5'd0:    alu_res = A + B;
            5'd1:    alu_res = A - B;
            5'd2:    alu_res = B;
            5'd3:    alu_res = A & B;
            5'd4:    alu_res = A ^ B;
            5'd5:    alu_res = A | B;
            5'd6:    alu_res = A << B[SHW-1:0];
            5'd7:    alu_res = A >> B[SHW-1:0];
            5'd8:    alu_res = $unsigned($signed(A) >>> B[SHW-1:0]);
            5'd9:    alu_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            5'd10:   alu_res = {{(WIDTH-1){1'b0}}, A < B};
            default: alu_res = '0;
        endcase
    end

    // Signedness per op: mulh/div/rem treat both signed, mulhsu only A.
    assign is_mul = (ALUCode >= 5'd11) && (ALUCode <= 5'd14);
    assign is_div = (ALUCode >= 5'd15) && (ALUCode <= 5'd18);
    assign a_sgn  = A[WIDTH-1] & ((ALUCode == 5'd12) | (ALUCode == 5'd13) |
                                  (ALUCode == 5'd15) | (ALUCode == 5'd17));
    assign b_sgn  = B[WIDTH-1] & ((ALUCode == 5'd12) | (ALUCode == 5'd15) | (ALUCode == 5'd17));
    assign a_mag  = a_sgn ? -A : A;
    assign b_mag  = b_sgn ? -B : B;

    // Shift-add multiply step: {acc,lo} holds partial product and multiplier.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_acc_n, mul_lo_n, mul_res;
    logic [2*WIDTH-1:0] prod, prod_s;
    assign mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_acc_n = mul_sum[WIDTH:1];
    assign mul_lo_n  = {mul_sum[0], lo_q[WIDTH-1:1]};
    assign prod      = {mul_acc_n, mul_lo_n};
    assign prod_s    = negq_q ? -prod : prod;
    assign mul_res   = (op_q == 5'd11) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];

    // Restoring divide step: acc is the partial remainder, lo shifts dividend out / quotient in.
    logic [WIDTH:0]   rsh, rdiff;
    logic             ge;
    logic [WIDTH-1:0] div_acc_n, div_lo_n, quo, rem, div_res;
    assign rsh       = {acc_q, lo_q[WIDTH-1]};
    assign rdiff     = rsh - {1'b0, opnd_q};
    assign ge        = rsh >= {1'b0, opnd_q};
    assign div_acc_n = ge ? rdiff[WIDTH-1:0] : rsh[WIDTH-1:0];
    assign div_lo_n  = {lo_q[WIDTH-2:0], ge};
    assign quo       = bz_q ? '1 : (negq_q ? -div_lo_n : div_lo_n);
    assign rem       = negr_q ? -div_acc_n : div_acc_n;
    assign div_res   = ((op_q == 5'd15) || (op_q == 5'd16)) ? quo : rem;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        opnd_d  = opnd_q;
        res_d   = res_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        bz_d    = bz_q;
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_MUL: begin
                    acc_d = mul_acc_n;
                    lo_d  = mul_lo_n;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        res_d   = mul_res;
                        state_d = S_DONE;
                    end
                end
                S_DIV: begin
                    acc_d = div_acc_n;
                    lo_d  = div_lo_n;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        res_d   = div_res;
                        state_d = S_DONE;
                    end
                end
                S_DONE:  if (out_ready) state_d = S_IDLE;
                default: ;
            endcase
            // Acceptance from DONE overrides the return to IDLE (back-to-back).
            if (accept) begin
                op_d   = ALUCode;
                negq_d = a_sgn ^ b_sgn;
                negr_d = a_sgn;
                bz_d   = (B == '0);
                acc_d  = '0;
                if (is_mul) begin
                    lo_d    = b_mag;
                    opnd_d  = a_mag;
                    cnt_d   = CW'(WIDTH);
                    state_d = S_MUL;
                end else if (is_div) begin
                    lo_d    = a_mag;
                    opnd_d  = b_mag;
                    cnt_d   = CW'(WIDTH);
                    state_d = S_DIV;
                end else begin
                    res_d   = alu_res;
                    state_d = S_DONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            res_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            bz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            opnd_q  <= opnd_d;
            res_q   <= res_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            bz_q    <= bz_d;
        end
    end
endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Directed bench for alu_muldiv_unit: 32-bit instance plus a 16-bit build.
module tb_alu_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset, flush, iv32, iv16, out_ready, sel16;
    logic [4:0]  code;
    logic [31:0] A, B;
    logic        rdy32, ov32, busy32, rdy16, ov16, busy16;
    logic [31:0] res32;
    logic [15:0] res16;
    logic        o_rdy, o_ov, o_busy;
    logic [31:0] o_res;
    int vectors = 0, miscompares = 0;
    int lat, bcnt;

    always #5 clk = ~clk;

    alu_muldiv_unit #(.WIDTH(32)) u32 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(iv32), .in_ready(rdy32),
        .ALUCode(code), .A(A), .B(B), .out_valid(ov32), .out_ready(out_ready),
        .ALUResult(res32), .busy(busy32));

    alu_muldiv_unit #(.WIDTH(16)) u16 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(iv16), .in_ready(rdy16),
        .ALUCode(code), .A(A[15:0]), .B(B[15:0]), .out_valid(ov16), .out_ready(out_ready),
        .ALUResult(res16), .busy(busy16));

    assign o_rdy  = sel16 ? rdy16 : rdy32;
    assign o_ov   = sel16 ? ov16 : ov32;
    assign o_busy = sel16 ? busy16 : busy32;
    assign o_res  = sel16 ? {16'h0, res16} : res32;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; presents the op and waits for out_valid, counting edges.
    task automatic issue(input string tag, input logic [4:0] c, input logic [31:0] a, b,
                         input int exp_lat, input logic [31:0] exp_res);
        code = c; A = a; B = b;
        if (sel16) iv16 = 1'b1; else iv32 = 1'b1;
        #1 check({tag, " in_ready"}, {31'b0, o_rdy}, 32'd1);
        lat = 0; bcnt = 0;
        do begin
            @(posedge clk); lat++;
            @(negedge clk); iv32 = 1'b0; iv16 = 1'b0;
            if (o_busy) bcnt++;
        end while (!o_ov && lat < 60);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check(tag, o_res, exp_res);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; iv32 = 1'b0; iv16 = 1'b0; out_ready = 1'b1;
        sel16 = 1'b0; code = '0; A = '0; B = '0;
        @(negedge clk); #1;
        check("rst out_valid", {31'b0, ov32}, 32'd0);
        check("rst busy", {31'b0, busy32}, 32'd0);
        check("rst result", res32, 32'd0);
        check("rst in_ready", {31'b0, rdy32}, 32'd1);
        @(negedge clk); reset = 1'b0;

        issue("add", 5'd0, 32'h7FFF_FFFF, 32'h1, 1, 32'h8000_0000);
        @(negedge clk);
        check("add pulse", {31'b0, ov32}, 32'd0);
        issue("sra", 5'd8, 32'h8000_0000, 32'h24, 1, 32'hF800_0000);
        issue("sltu", 5'd10, 32'h1, 32'hFFFF_FFFF, 1, 32'h1);
        issue("slt", 5'd9, 32'h1, 32'hFFFF_FFFF, 1, 32'h0);
        issue("code25", 5'd25, 32'h1234, 32'h5678, 1, 32'h0);
        issue("mulh", 5'd12, 32'hFFFF_FFFF, 32'h2, 33, 32'hFFFF_FFFF);
        check("mulh busy cycles", 32'(bcnt), 32'd32);
        issue("mul", 5'd11, 32'hFFFF_FFFF, 32'h2, 33, 32'hFFFF_FFFE);
        issue("mulhsu", 5'd13, 32'hFFFF_FFFF, 32'h2, 33, 32'hFFFF_FFFF);
        issue("mulhu", 5'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE);
        issue("divu by0", 5'd16, 32'd100, 32'd0, 33, 32'hFFFF_FFFF);
        issue("remu by0", 5'd18, 32'd100, 32'd0, 33, 32'd100);
        issue("div ovf", 5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000);
        issue("rem ovf", 5'd17, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0);
        issue("divu", 5'd16, 32'd1000, 32'd7, 33, 32'd142);

        // Backpressure: hold div result, then chain rem in the release edge.
        @(negedge clk); out_ready = 1'b0;
        issue("div bp", 5'd15, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp result", res32, 32'hFFFF_FFFD);
            check("bp valid", {31'b0, ov32}, 32'd1);
            check("bp in_ready", {31'b0, rdy32}, 32'd0);
        end
        out_ready = 1'b1;
        issue("rem b2b", 5'd17, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF);

        // Flush on the tenth iteration with a competing request.
        code = 5'd16; A = 32'd1000; B = 32'd3; iv32 = 1'b1;
        @(negedge clk); iv32 = 1'b0;
        repeat (9) @(negedge clk);
        check("pre-flush busy", {31'b0, busy32}, 32'd1);
        flush = 1'b1; iv32 = 1'b1; code = 5'd0; A = 32'd1; B = 32'd1;
        @(negedge clk); flush = 1'b0; iv32 = 1'b0;
        check("flush valid", {31'b0, ov32}, 32'd0);
        check("flush busy", {31'b0, busy32}, 32'd0);
        check("flush in_ready", {31'b0, rdy32}, 32'd1);
        check("flush keeps result", res32, 32'hFFFF_FFFF);
        @(negedge clk);
        check("flush no accept", {31'b0, ov32}, 32'd0);

        // Asynchronous reset mid-multiply.
        code = 5'd14; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; iv32 = 1'b1;
        @(negedge clk); iv32 = 1'b0;
        repeat (4) @(negedge clk);
        check("pre-reset busy", {31'b0, busy32}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async rst busy", {31'b0, busy32}, 32'd0);
        check("async rst valid", {31'b0, ov32}, 32'd0);
        check("async rst result", res32, 32'd0);
        check("async rst in_ready", {31'b0, rdy32}, 32'd1);
        @(negedge clk); reset = 1'b0;

        // 16-bit build.
        sel16 = 1'b1;
        issue("w16 mulhu", 5'd14, 32'hFFFF, 32'hFFFF, 17, 32'h0000_FFFE);
        issue("w16 sll", 5'd6, 32'h0001, 32'h0013, 1, 32'h0000_0008);
        issue("w16 div", 5'd15, 32'hFFF9, 32'h0002, 17, 32'h0000_FFFD);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
